// File: rtl/v_rams_dp_pipe_if.sv
// Port bundle for v_rams_dp_pipe: port A read/write and port B read-only signals.
// Parity injection and error flags exist only when RAMS_PARITY_EN is defined.
interface v_rams_dp_pipe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 7
);
    logic              a_en;
    logic              a_we;
    logic              a_ce;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_di;
    logic [DATA_W-1:0] a_do;
    logic              a_vld;
    logic              b_en;
    logic              b_ce;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_do;
    logic              b_vld;
`ifdef RAMS_PARITY_EN
    logic              a_perr_inj;
    logic              a_perr;
    logic              b_perr;
`endif

    modport master (
        output a_en, a_we, a_ce, a_addr, a_di, b_en, b_ce, b_addr,
`ifdef RAMS_PARITY_EN
        output a_perr_inj,
        input  a_perr, b_perr,
`endif
        input  a_do, a_vld, b_do, b_vld
    );

    modport slave (
        input  a_en, a_we, a_ce, a_addr, a_di, b_en, b_ce, b_addr,
`ifdef RAMS_PARITY_EN
        input  a_perr_inj,
        output a_perr, b_perr,
`endif
        output a_do, a_vld, b_do, b_vld
    );
endinterface

// File: rtl/v_rams_dp_pipe.sv
// Simple-dual-port RAM with an array read register plus OUT_REGS output stages per port,
// valid tracking and per-port pipeline stall. Optional parity via macro RAMS_PARITY_EN.
module v_rams_dp_pipe #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned OUT_REGS   = 1,
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    v_rams_dp_pipe_if.slave    bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NSTG  = OUT_REGS + 1;
`ifdef RAMS_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned MEM_W    = DATA_W + PAR_W;
    localparam bit          WR_FIRST = (WRITE_MODE == 1);

    // Stage payload: bit MEM_W = valid, below it the returned word (parity bit replaced by the error flag).
    logic [MEM_W-1:0]               mem_q [DEPTH];
    logic [MEM_W-1:0]               wr_word_c;
    logic                           a_wr_c;
    logic [1:0]                     ce_c;
    logic [1:0]                     iss_c;
    logic [1:0][MEM_W-1:0]          rd_c;
    logic [1:0][NSTG-1:0][MEM_W:0]  st_q;
    logic [1:0][NSTG-1:0][MEM_W:0]  st_d;

    function automatic logic [MEM_W-1:0] chk_word(input logic [MEM_W-1:0] w);
`ifdef RAMS_PARITY_EN
        return {^w, w[DATA_W-1:0]};
`else
        return w;
`endif
    endfunction

    // Write word, issue conditions and collision-aware read data.
    always_comb begin
        a_wr_c = bus.a_en & bus.a_we;
        ce_c   = {bus.b_ce, bus.a_ce};
        iss_c  = {bus.b_en & bus.b_ce, bus.a_en & bus.a_ce};
`ifdef RAMS_PARITY_EN
        wr_word_c = {(^bus.a_di) ^ bus.a_perr_inj, bus.a_di};
`else
        wr_word_c = bus.a_di;
`endif
        rd_c[0] = (WR_FIRST && a_wr_c) ? wr_word_c : mem_q[bus.a_addr];
        rd_c[1] = (WR_FIRST && a_wr_c && (bus.a_addr == bus.b_addr)) ? wr_word_c
                                                                     : mem_q[bus.b_addr];
    end

    // Array storage; contents survive reset but writes are blocked while it is held.
    always_ff @(posedge clk) begin
        if (rst_n && a_wr_c) begin
            mem_q[bus.a_addr] <= wr_word_c;
        end
    end

    // Each port's stages shift together only when its ce is high.
    always_comb begin
        st_d = st_q;
        for (int p = 0; p < 2; p++) begin
            if (ce_c[p]) begin
                st_d[p][0] = iss_c[p] ? {1'b1, chk_word(rd_c[p])}
                                      : {1'b0, st_q[p][0][MEM_W-1:0]};
                for (int s = 1; s < int'(NSTG); s++) begin
                    st_d[p][s] = st_q[p][s-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= '0;
        end else begin
            st_q <= st_d;
        end
    end

    assign bus.a_do  = st_q[0][NSTG-1][DATA_W-1:0];
    assign bus.a_vld = st_q[0][NSTG-1][MEM_W];
    assign bus.b_do  = st_q[1][NSTG-1][DATA_W-1:0];
    assign bus.b_vld = st_q[1][NSTG-1][MEM_W];
`ifdef RAMS_PARITY_EN
    assign bus.a_perr = st_q[0][NSTG-1][DATA_W];
    assign bus.b_perr = st_q[1][NSTG-1][DATA_W];
`endif

endmodule

// File: tb/tb_v_rams_dp_pipe.sv
// Bench for v_rams_dp_pipe: four configurations driven in lockstep against a queue-based
// reference model (memory array + per-port delay-by-ce-cycles queues).
module tb_v_rams_dp_pipe;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned NI    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          a_en, a_we, a_ce, b_en, b_ce, a_inj;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_di;

    logic [DW-1:0] a_do_w [NI];
    logic [DW-1:0] b_do_w [NI];
    logic          a_vld_w [NI];
    logic          b_vld_w [NI];
    logic          a_perr_w [NI];
    logic          b_perr_w [NI];

    // Instance g: OUT_REGS = {0,1,1,2}, write-first for g = 0 and 2.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned ORG = (g == 0) ? 0 : ((g == 3) ? 2 : 1);
        localparam int unsigned WMG = (g == 0 || g == 2) ? 1 : 0;
        v_rams_dp_pipe_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.a_en   = a_en;
        assign bus.a_we   = a_we;
        assign bus.a_ce   = a_ce;
        assign bus.a_addr = a_addr;
        assign bus.a_di   = a_di;
        assign bus.b_en   = b_en;
        assign bus.b_ce   = b_ce;
        assign bus.b_addr = b_addr;
`ifdef RAMS_PARITY_EN
        assign bus.a_perr_inj = a_inj;
        assign a_perr_w[g]    = bus.a_perr;
        assign b_perr_w[g]    = bus.b_perr;
`else
        assign a_perr_w[g] = 1'b0;
        assign b_perr_w[g] = 1'b0;
`endif
        v_rams_dp_pipe #(.DATA_W(DW), .ADDR_W(AW), .OUT_REGS(ORG), .WRITE_MODE(WMG)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign a_do_w[g]  = bus.a_do;
        assign b_do_w[g]  = bus.b_do;
        assign a_vld_w[g] = bus.a_vld;
        assign b_vld_w[g] = bus.b_vld;
    end

    typedef struct packed {
        logic          v;
        logic          e;
        logic [DW-1:0] d;
    } ent_t;

    logic [DW-1:0] mem_m [DEPTH];
    logic          err_m [DEPTH];
    ent_t          pm [2*NI][$];
    int            n_vec = 0;
    int            n_err = 0;

    function automatic int or_of(input int g);
        return (g == 0) ? 0 : ((g == 3) ? 2 : 1);
    endfunction

    function automatic bit wf_of(input int g);
        return (g == 0 || g == 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2*NI; k++) begin
            pm[k].delete();
            for (int i = 0; i < or_of(k/2) + 1; i++) pm[k].push_back('0);
        end
    endtask

    // A port's result appears after exactly (1 + OUT_REGS) ce-enabled edges.
    task automatic adv(input int k, input logic ce, input logic iss,
                       input logic [DW-1:0] d, input logic e);
        ent_t n;
        if (ce) begin
            n.v = iss;
            n.d = iss ? d : pm[k][0].d;
            n.e = iss ? e : pm[k][0].e;
            pm[k].push_front(n);
            void'(pm[k].pop_back());
        end
    endtask

    task automatic check_all();
        ent_t ea, eb;
        for (int g = 0; g < NI; g++) begin
            ea = pm[2*g][$];
            eb = pm[2*g+1][$];
            chk($sformatf("g%0d_a_vld", g), 32'(a_vld_w[g]), 32'(ea.v));
            chk($sformatf("g%0d_b_vld", g), 32'(b_vld_w[g]), 32'(eb.v));
            if (ea.v) chk($sformatf("g%0d_a_do", g), 32'(a_do_w[g]), 32'(ea.d));
            if (eb.v) chk($sformatf("g%0d_b_do", g), 32'(b_do_w[g]), 32'(eb.d));
`ifdef RAMS_PARITY_EN
            if (ea.v) chk($sformatf("g%0d_a_perr", g), 32'(a_perr_w[g]), 32'(ea.e));
            if (eb.v) chk($sformatf("g%0d_b_perr", g), 32'(b_perr_w[g]), 32'(eb.e));
`endif
        end
    endtask

    task automatic zero_chk(input string tag);
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("%s_g%0d_a_vld", tag, g), 32'(a_vld_w[g]), 32'd0);
            chk($sformatf("%s_g%0d_b_vld", tag, g), 32'(b_vld_w[g]), 32'd0);
            chk($sformatf("%s_g%0d_a_do", tag, g), 32'(a_do_w[g]), 32'd0);
            chk($sformatf("%s_g%0d_b_do", tag, g), 32'(b_do_w[g]), 32'd0);
`ifdef RAMS_PARITY_EN
            chk($sformatf("%s_g%0d_a_perr", tag, g), 32'(a_perr_w[g]), 32'd0);
            chk($sformatf("%s_g%0d_b_perr", tag, g), 32'(b_perr_w[g]), 32'd0);
`endif
        end
    endtask

    // One clock edge: update the model from the inputs seen at that edge, then compare.
    task automatic step();
        logic [DW-1:0] ad, bd;
        logic          ae, be;
        bit            wa;
        @(posedge clk);
        if (rst_n) begin
            wa = a_en && a_we;
            for (int g = 0; g < NI; g++) begin
                if (wa && wf_of(g)) begin ad = a_di; ae = a_inj; end
                else begin ad = mem_m[a_addr]; ae = err_m[a_addr]; end
                if (wa && wf_of(g) && a_addr == b_addr) begin bd = a_di; be = a_inj; end
                else begin bd = mem_m[b_addr]; be = err_m[b_addr]; end
                adv(2*g, a_ce, a_en && a_ce, ad, ae);
                adv(2*g+1, b_ce, b_en && b_ce, bd, be);
            end
            if (wa) begin
                mem_m[a_addr] = a_di;
                err_m[a_addr] = a_inj;
            end
        end
        #1;
        check_all();
    endtask

    task automatic cyc(input bit ae, input bit aw, input bit ac, input logic [AW-1:0] aa,
                       input logic [DW-1:0] ad, input bit be, input bit bc,
                       input logic [AW-1:0] ba, input bit inj = 1'b0);
        @(negedge clk);
        a_en = ae; a_we = aw; a_ce = ac; a_addr = aa; a_di = ad;
        b_en = be; b_ce = bc; b_addr = ba; a_inj = inj;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b0, 1'b1, '0);
    endtask

    // Asynchronous reset while reads and a write are in flight; the write must be dropped.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        a_en = 1'b1; a_we = 1'b1; a_ce = 1'b1; b_en = 1'b1; b_ce = 1'b1;
        a_addr = AW'($urandom); a_di = DW'($urandom); b_addr = AW'($urandom);
        #1;
        reset_model();
        zero_chk({tag, "_async"});
        @(posedge clk);
        #1;
        zero_chk({tag, "_hold"});
        @(negedge clk);
        rst_n = 1'b1;
        a_en = 1'b0; a_we = 1'b0; b_en = 1'b0;
        step();
    endtask

    logic [DW-1:0] seen [$];

    initial begin
        rst_n = 1'b1;
        a_en = 1'b0; a_we = 1'b0; a_ce = 1'b0; a_addr = '0; a_di = '0;
        b_en = 1'b0; b_ce = 1'b0; b_addr = '0; a_inj = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) err_m[i] = 1'b0;
        reset_model();
        do_reset("rst0");

        // Fill the array with writes that issue no reads (a_ce low).
        for (int i = 0; i < int'(DEPTH); i++)
            cyc(1'b1, 1'b1, 1'b0, AW'(i), DW'($urandom), 1'b0, 1'b1, '0);
        idle(3);

        // Write then read on B: OUT_REGS=1 answers two edges after issue.
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 16'hA5A5, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 4'd3);
        chk("lat_b_vld_e1", 32'(b_vld_w[1]), 32'd0);
        idle(1);
        chk("lat_b_vld_e2", 32'(b_vld_w[1]), 32'd1);
        chk("lat_b_do_e2", 32'(b_do_w[1]), 32'hA5A5);
        idle(1);
        chk("lat_b_vld_e3", 32'(b_vld_w[1]), 32'd0);
        idle(2);

        // Same-address collision: read-first vs write-first.
        cyc(1'b1, 1'b1, 1'b0, 4'd5, 16'h1111, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, 1'b1, 4'd5, 16'h2222, 1'b1, 1'b1, 4'd5);
        idle(1);
        chk("coll_rf_a_do", 32'(a_do_w[1]), 32'h1111);
        chk("coll_rf_b_do", 32'(b_do_w[1]), 32'h1111);
        chk("coll_wf_a_do", 32'(a_do_w[2]), 32'h2222);
        chk("coll_wf_b_do", 32'(b_do_w[2]), 32'h2222);
        idle(3);

        // Port B stall for three cycles between issues.
        cyc(1'b1, 1'b1, 1'b0, 4'd0, 16'd10, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, 1'b0, 4'd1, 16'd11, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, 1'b0, 4'd2, 16'd12, 1'b0, 1'b1, '0);
        idle(4);
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            if (i < 2)      cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, AW'(i));
            else if (i < 5) cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 4'd2);
            else if (i == 5) cyc(1'b0, 1'b0, 1'b1, '0, '0, 1'b1, 1'b1, 4'd2);
            else            idle(1);
            if (b_vld_w[3]) seen.push_back(b_do_w[3]);
        end
        chk("stall_count", 32'(seen.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < seen.size()) chk($sformatf("stall_order%0d", i), 32'(seen[i]), 32'(10 + i));

        // Write with a_ce low issues no read; the data must still land.
        cyc(1'b1, 1'b1, 1'b0, 4'd7, 16'h0BEE, 1'b0, 1'b1, '0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b1, 4'd7, '0, 1'b0, 1'b1, '0);
        idle(2);
        chk("ce0_wr_a_do", 32'(a_do_w[3]), 32'h0BEE);
        idle(1);

        // Randomised traffic with a mid-flight reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("rst_mid");
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                AW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, AW'($urandom),
`ifdef RAMS_PARITY_EN
                $urandom_range(0, 3) == 0);
`else
                1'b0);
`endif
        end
        idle(3);

`ifdef RAMS_PARITY_EN
        // Injected parity error seen on both ports, cleared by a clean rewrite.
        cyc(1'b1, 1'b1, 1'b0, 4'd9, 16'h00FF, 1'b0, 1'b1, '0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 4'd9, '0, 1'b1, 1'b1, 4'd9);
        idle(1);
        chk("par_inj_a_perr", 32'(a_perr_w[1]), 32'd1);
        chk("par_inj_b_perr", 32'(b_perr_w[1]), 32'd1);
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 4'd9, 16'h00FF, 1'b0, 1'b1, '0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 4'd9, '0, 1'b1, 1'b1, 4'd9);
        idle(1);
        chk("par_clr_a_perr", 32'(a_perr_w[1]), 32'd0);
        chk("par_clr_b_perr", 32'(b_perr_w[1]), 32'd0);
        idle(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/v_rams_dp_pipe.md
# v_rams_dp_pipe

Parametrised simple-dual-port block RAM with a configurable output pipeline and valid tracking. Port A writes and reads; port B is read-only. Both ports share one clock. Each port has a valid flag that follows every read through its output registers, and a per-port pipeline clock enable that stalls its output pipeline. It is the general-purpose successor for buffers and lookup tables that need more than one fixed output-register stage.

## Interface
Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 7, address width in bits; depth = 2**ADDR_W
- OUT_REGS, 1, extra output register stages after the array read register; legal values 0, 1, 2
- WRITE_MODE, 0, collision read policy: 0 = read-first (old data), 1 = write-first (new data)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_en  in  1  port A access enable
- a_we  in  1  port A write enable, qualified by a_en
- a_ce  in  1  port A pipeline clock enable
- a_addr  in  ADDR_W  port A address
- a_di  in  DATA_W  port A write data
- a_do  out  DATA_W  port A read data
- a_vld  out  1  a_do holds the result of a port A read
- b_en  in  1  port B read enable
- b_ce  in  1  port B pipeline clock enable
- b_addr  in  ADDR_W  port B address
- b_do  out  DATA_W  port B read data
- b_vld  out  1  b_do holds the result of a port B read
- a_perr_inj, a_perr, b_perr: present only with RAMS_PARITY_EN (see Configuration)

## Operation
- Write: the word at a_addr is written in any cycle with a_en=1 and a_we=1, regardless of a_ce.
- Read issue: a port A read issues when a_en=1 and a_ce=1; this includes write cycles. A port B read issues when b_en=1 and b_ce=1. If en=1 and ce=0, no read issues and the request is dropped. A write in that cycle still occurs.
- Pipeline: stage 0 is the array read register, followed by OUT_REGS output stages. Every stage of a port, data and valid together, advances only when that port's ce=1. When ce=0, all stages hold.
- Valid: the stage 0 valid bit is loaded with the issue condition whenever ce=1. The valid bit travels with its data. a_vld and b_vld are the last-stage valid bits.
- Port A write data returned: read-first returns the prior contents; write-first returns a_di.
- Collision: when B reads the address A writes in the same cycle, WRITE_MODE applies to B as well. With 0, B returns the old data; with 1, a_di is forwarded to B.
- Data registers are not cleared when vld is low; they retain their last loaded value.

## Timing
- Read latency: 1 + OUT_REGS ce=1 cycles from issue to vld. With ce tied high, that is 1, 2 or 3 clock edges.
- Throughput: one read per port per cycle, with no bubbles.
- Reset values: a_do=0, b_do=0, a_vld=0, b_vld=0, and all intermediate stages 0.
- Reset mid-operation: all in-flight reads are discarded. Array contents are preserved.
- Writes are ignored while rst_n=0.
- The first read may issue in the first cycle after rst_n deasserts.
- Memory contents after power-up are undefined. Verification must write before reading.

## Configuration
- Macro: RAMS_PARITY_EN.
- Defined:
  - The array stores DATA_W+1 bits: data plus an even-parity bit computed from a_di at write time.
  - Input a_perr_inj (1 bit): when high during a write, the stored parity bit is inverted.
  - Outputs a_perr and b_perr (1 bit each) carry a parity mismatch flag for the word being returned, pipelined alongside do and vld. A flag is meaningful only while the matching vld=1.
  - Reset value of a_perr and b_perr is 0.
  - With write-first forwarding, the parity check uses the forwarded word, including the effect of injection.
- Undefined: the parity ports are absent, no parity storage exists, and the array is DATA_W wide.

## Test plan
- OUT_REGS=1, ce tied high: write 16'hA5A5 to address 3; next cycle read address 3 on port B → b_vld=1 and b_do=16'hA5A5 exactly 2 edges after issue, b_vld=0 the following cycle.
- WRITE_MODE=0, address 5 holds 16'h1111: write 16'h2222 to 5 on A while B reads 5 → a_do=b_do=16'h1111. The same stimulus with WRITE_MODE=1 → both return 16'h2222.
- Stall: issue B reads of addresses 0,1,2 back-to-back (contents 10,11,12), drop b_ce for 3 cycles after the second issue → b_do/b_vld hold steady during the stall. Outputs then emerge in order 10,11,12 with no loss or duplication.
- en=1, ce=0 on A with a_we=1, a_di=16'h0BEE at address 7 → no a_vld pulse. A later read of address 7 returns 16'h0BEE.
- Reset mid-flight: OUT_REGS=2, issue reads each cycle, assert rst_n low for 1 cycle → all outputs 0 immediately (asynchronously). Previously written data is still readable after release.
- RAMS_PARITY_EN: write 16'h00FF to address 9 with a_perr_inj=1, then read it on both ports → a_perr=b_perr=1 with vld. Rewrite with inject=0 → both flags 0.
